// File: rtl/mbnet_pkg.sv
// Shared types and helpers for the MobileNet depthwise weight path.
// Holds the kernel-loader FSM state encoding and the kernel word-count helper.
package mbnet_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    // Words per square kernel of edge k (KWORDS = KSIZE**2).
    function automatic int kwords(input int k);
        return k * k;
    endfunction

endpackage

// File: rtl/dw_kernel_loader.sv
// Streams one depthwise kernel from the weight buffer into a shadow register and swaps it into the active slot.
// Define DW_KERNEL_LOADER_DBUF_EN to allow fetching the next kernel while the active one is still in use.
module dw_kernel_loader
    import mbnet_pkg::*;
#(
    parameter int DW    = 32,
    parameter int KSIZE = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fetch_req,
    output logic                          dw_ready,
    input  logic [DW-1:0]                 dw_out,
    output logic [DW*kwords(KSIZE)-1:0]   kern_out,
    output logic                          kern_valid,
    input  logic                          kern_use_done,
    output logic                          shadow_full,
    output logic [15:0]                   swap_cnt
);

    localparam int KWORDS = kwords(KSIZE);
    localparam int IDX_W  = (KWORDS > 1) ? $clog2(KWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KWORDS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [DW*KWORDS-1:0]   shadow;
    logic                   last_word;
    logic                   swap;
    logic                   fetch_permit;

`ifdef DW_KERNEL_LOADER_DBUF_EN
    assign fetch_permit = 1'b1;
`else
    // Single buffer: the shadow may only fill once the active slot is free.
    assign fetch_permit = ~kern_valid;
`endif

    assign last_word = (state == FETCH) && (idx == LAST_IDX);
    assign swap      = shadow_full && (!kern_valid || kern_use_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dw_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req && !shadow_full && fetch_permit) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                dw_ready = 1'b1;
                if (last_word) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (last_word) begin
            idx <= '0;
        end else if (state == FETCH) begin
            idx <= idx + 1'b1;
        end
    end

    // Shadow contents are never exposed before a full fetch, so they carry no reset.
    always_ff @(posedge clk) begin
        if (dw_ready) begin
            shadow[int'(idx)*DW +: DW] <= dw_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_full <= 1'b0;
            kern_valid  <= 1'b0;
            kern_out    <= '0;
            swap_cnt    <= '0;
        end else begin
            if (swap) begin
                kern_out    <= shadow;
                kern_valid  <= 1'b1;
                shadow_full <= 1'b0;
                swap_cnt    <= swap_cnt + 16'd1;
            end else begin
                if (last_word) begin
                    shadow_full <= 1'b1;
                end
                if (kern_use_done && kern_valid) begin
                    kern_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dw_kernel_loader.sv
// Directed self-checking bench for dw_kernel_loader (KSIZE=3, DW=32).
// Checks the single- or double-buffer behaviour selected by DW_KERNEL_LOADER_DBUF_EN.
module tb_dw_kernel_loader;

    localparam int DW    = 32;
    localparam int KSIZE = 3;
    localparam int KW    = 9;

    logic               clk = 1'b0;
    logic               rst;
    logic               fetch_req;
    logic               dw_ready;
    logic [DW-1:0]      dw_out;
    logic [DW*KW-1:0]   kern_out;
    logic               kern_valid;
    logic               kern_use_done;
    logic               shadow_full;
    logic [15:0]        swap_cnt;

    int errors = 0;
    int checks = 0;

    dw_kernel_loader #(.DW(DW), .KSIZE(KSIZE)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req     (fetch_req),
        .dw_ready      (dw_ready),
        .dw_out        (dw_out),
        .kern_out      (kern_out),
        .kern_valid    (kern_valid),
        .kern_use_done (kern_use_done),
        .shadow_full   (shadow_full),
        .swap_cnt      (swap_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW*KW-1:0] kvec(input int base);
        logic [DW*KW-1:0] v;
        v = '0;
        for (int i = 0; i < KW; i++) v[i*DW +: DW] = DW'(base + i);
        return v;
    endfunction

    // Raises fetch_req and feeds base+k on each dw_ready cycle; returns at the
    // first cycle after the stream ends, with nready = number of ready cycles.
    task automatic run_fetch(input int base, output int nready);
        int k;
        k = 0;
        fetch_req = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (dw_ready) begin
                dw_out    = DW'(base + k);
                k++;
                fetch_req = 1'b0;
            end else if (k > 0) begin
                break;
            end
            @(posedge clk); #1;
        end
        fetch_req = 1'b0;
        nready = k;
    endtask

    task automatic pulse_use_done();
        kern_use_done = 1'b1;
        @(posedge clk); #1;
        kern_use_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dw_ready !== 1'b0) begin errors++; $display("FAIL reset_dw_ready: got %b want 0", dw_ready); end
        checks++; if (kern_valid !== 1'b0) begin errors++; $display("FAIL reset_kern_valid: got %b want 0", kern_valid); end
        checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL reset_shadow_full: got %b want 0", shadow_full); end
        checks++; if (kern_out !== '0) begin errors++; $display("FAIL reset_kern_out: got %h want 0", kern_out); end
        checks++; if (swap_cnt !== 16'd0) begin errors++; $display("FAIL reset_swap_cnt: got %0d want 0", swap_cnt); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_fetch();
        int n;
        run_fetch(1, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL basic_ready_cycles: got %0d want 9", n); end
        checks++; if (shadow_full !== 1'b1) begin errors++; $display("FAIL basic_shadow_full: got %b want 1", shadow_full); end
        checks++; if (kern_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b want 0", kern_valid); end
        @(posedge clk); #1;
        checks++; if (kern_valid !== 1'b1) begin errors++; $display("FAIL basic_kern_valid: got %b want 1", kern_valid); end
        checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL basic_shadow_clear: got %b want 0", shadow_full); end
        checks++; if (kern_out !== kvec(1)) begin errors++; $display("FAIL basic_kern_out: got %h want %h", kern_out, kvec(1)); end
        checks++; if (swap_cnt !== 16'd1) begin errors++; $display("FAIL basic_swap_cnt: got %0d want 1", swap_cnt); end
    endtask

`ifdef DW_KERNEL_LOADER_DBUF_EN
    task automatic test_overlap();
        int n;
        run_fetch(10, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL dbuf_ready_cycles: got %0d want 9", n); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (shadow_full !== 1'b1) begin errors++; $display("FAIL dbuf_shadow_full: got %b want 1", shadow_full); end
        checks++; if (kern_out !== kvec(1)) begin errors++; $display("FAIL dbuf_hold_a: got %h want %h", kern_out, kvec(1)); end
        checks++; if (swap_cnt !== 16'd1) begin errors++; $display("FAIL dbuf_cnt_hold: got %0d want 1", swap_cnt); end
        pulse_use_done();
        checks++; if (kern_out !== kvec(10)) begin errors++; $display("FAIL dbuf_swap_b: got %h want %h", kern_out, kvec(10)); end
        checks++; if (kern_valid !== 1'b1) begin errors++; $display("FAIL dbuf_valid: got %b want 1", kern_valid); end
        checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL dbuf_shadow_clear: got %b want 0", shadow_full); end
        checks++; if (swap_cnt !== 16'd2) begin errors++; $display("FAIL dbuf_swap_cnt: got %0d want 2", swap_cnt); end
    endtask
`else
    task automatic test_overlap();
        int n;
        int early;
        early = 0;
        fetch_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (dw_ready !== 1'b0) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL sbuf_blocked: got %0d ready cycles want 0", early); end
        pulse_use_done();
        checks++; if (kern_valid !== 1'b0) begin errors++; $display("FAIL sbuf_freed: got %b want 0", kern_valid); end
        checks++; if (dw_ready !== 1'b0) begin errors++; $display("FAIL sbuf_ready_same_edge: got %b want 0", dw_ready); end
        run_fetch(10, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL sbuf_ready_cycles: got %0d want 9", n); end
        checks++; if (shadow_full !== 1'b1) begin errors++; $display("FAIL sbuf_shadow_full: got %b want 1", shadow_full); end
        @(posedge clk); #1;
        checks++; if (kern_out !== kvec(10)) begin errors++; $display("FAIL sbuf_kern_out: got %h want %h", kern_out, kvec(10)); end
        checks++; if (swap_cnt !== 16'd2) begin errors++; $display("FAIL sbuf_swap_cnt: got %0d want 2", swap_cnt); end
    endtask
`endif

    task automatic test_use_done();
        pulse_use_done();
        checks++; if (kern_valid !== 1'b0) begin errors++; $display("FAIL done_clears_valid: got %b want 0", kern_valid); end
        checks++; if (swap_cnt !== 16'd2) begin errors++; $display("FAIL done_cnt: got %0d want 2", swap_cnt); end
        pulse_use_done();
        checks++; if (kern_valid !== 1'b0) begin errors++; $display("FAIL idle_done_valid: got %b want 0", kern_valid); end
        checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL idle_done_shadow: got %b want 0", shadow_full); end
        checks++; if (dw_ready !== 1'b0) begin errors++; $display("FAIL idle_done_ready: got %b want 0", dw_ready); end
        checks++; if (swap_cnt !== 16'd2) begin errors++; $display("FAIL idle_done_cnt: got %0d want 2", swap_cnt); end
        checks++; if (kern_out !== kvec(10)) begin errors++; $display("FAIL idle_done_kern: got %h want %h", kern_out, kvec(10)); end
    endtask

    task automatic test_reset_mid_fetch();
        int k;
        int n;
        k = 0;
        fetch_req = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (dw_ready) begin
                dw_out    = DW'(50 + k);
                fetch_req = 1'b0;
                if (k == 4) break;
                k++;
            end
            @(posedge clk); #1;
        end
        fetch_req = 1'b0;
        checks++; if (k !== 4) begin errors++; $display("FAIL mid_reached_k4: got %0d want 4", k); end
        #2 rst = 1'b1;
        #1;
        checks++; if (dw_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", dw_ready); end
        checks++; if (kern_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", kern_valid); end
        checks++; if (shadow_full !== 1'b0) begin errors++; $display("FAIL mid_rst_shadow: got %b want 0", shadow_full); end
        checks++; if (kern_out !== '0) begin errors++; $display("FAIL mid_rst_kern: got %h want 0", kern_out); end
        checks++; if (swap_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", swap_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_fetch(21, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL refetch_cycles: got %0d want 9", n); end
        @(posedge clk); #1;
        checks++; if (kern_out !== kvec(21)) begin errors++; $display("FAIL refetch_kern: got %h want %h", kern_out, kvec(21)); end
        checks++; if (swap_cnt !== 16'd1) begin errors++; $display("FAIL refetch_cnt: got %0d want 1", swap_cnt); end
    endtask

    task automatic test_swap_wrap();
        int n;
        force dut.swap_cnt = 16'hFFFF;
        #1;
        release dut.swap_cnt;
        pulse_use_done();
        checks++; if (swap_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %0h want ffff", swap_cnt); end
        run_fetch(31, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL wrap_cycles: got %0d want 9", n); end
        @(posedge clk); #1;
        checks++; if (swap_cnt !== 16'd0) begin errors++; $display("FAIL wrap_cnt: got %0d want 0", swap_cnt); end
        checks++; if (kern_out !== kvec(31)) begin errors++; $display("FAIL wrap_kern: got %h want %h", kern_out, kvec(31)); end
    endtask

    initial begin
        rst           = 1'b1;
        fetch_req     = 1'b0;
        dw_out        = '0;
        kern_use_done = 1'b0;
        test_reset();
        test_basic_fetch();
        test_overlap();
        test_use_done();
        test_reset_mid_fetch();
        test_swap_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
